// File: rtl/noc_src_ni.sv
// Source network interface: buffers host flits in a small FIFO and injects
// them into the local router port, tracking per-VC credits and keeping each
// packet on a single virtual channel from head to tail.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | between packets; a head flit picks a free unlocked VC
// S_SEND | packet open on cur_vc; body/tail flits follow on that VC
module noc_src_ni #(
    parameter int FIFO_DEPTH = 4,
    parameter int VC_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [1:0]  my_xpos,
    input  logic [1:0]  my_ypos,
    input  logic [34:0] h_data,
    input  logic        h_valid,
    output logic        h_ready,
    output logic [34:0] odata,
    output logic        ovalid,
    output logic        ovch,
    input  logic [1:0]  iack,
    input  logic [1:0]  irdy,
    input  logic [1:0]  ilck,
    output logic        err,
    output logic        idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(VC_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(VC_DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        state, state_nxt;
    logic [34:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          rdy_en;
    logic          full, empty, push, pop;
    logic [34:0]   head, stamped;
    logic [1:0]    htype;
    logic [CW-1:0] cred [2];
    logic [1:0]    elig, qual, iss_on, at_max;
    logic          rr, rr_nxt, cur_vc, cur_vc_nxt;
    logic          issue, issue_vc, disc_err, ack_err;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign h_ready = rdy_en && !full;
    assign push    = h_valid && h_ready;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign htype   = head[34:33];

    // Head-type flits (01/11) carry the source coordinates in bits [7:4].
    always_comb begin
        stamped = head;
        if (head[33]) stamped[7:4] = {my_ypos, my_xpos};
    end

    assign elig[0]   = (cred[0] != '0) && irdy[0];
    assign elig[1]   = (cred[1] != '0) && irdy[1];
    assign qual      = elig & ~ilck;
    assign at_max[0] = (cred[0] == CRED_MAX);
    assign at_max[1] = (cred[1] == CRED_MAX);
    assign iss_on[0] = issue && !issue_vc;
    assign iss_on[1] = issue && issue_vc;
    assign ack_err   = |(iack & ~iss_on & at_max);
    assign idle      = empty && (state == S_IDLE) && at_max[0] && at_max[1];

    // Issue decision, VC selection and next-state logic.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_vc   = 1'b0;
        disc_err   = 1'b0;
        rr_nxt     = rr;
        cur_vc_nxt = cur_vc;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    if (htype[0]) begin
                        if (qual == 2'b11) begin
                            issue    = 1'b1;
                            issue_vc = rr;
                            rr_nxt   = ~rr;
                        end else if (qual[0]) begin
                            issue    = 1'b1;
                            issue_vc = 1'b0;
                        end else if (qual[1]) begin
                            issue    = 1'b1;
                            issue_vc = 1'b1;
                        end
                        if (issue && htype == 2'b01) begin
                            state_nxt  = S_SEND;
                            cur_vc_nxt = issue_vc;
                        end
                    end else begin
                        disc_err = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (!empty) begin
                    if (htype[0]) begin
                        disc_err = 1'b1;
                    end else if (elig[cur_vc]) begin
                        issue    = 1'b1;
                        issue_vc = cur_vc;
                        if (htype == 2'b10) state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pop = issue || disc_err;

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= h_data;
    end

    // FIFO pointers and the post-reset enable for h_ready.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FSM state, round-robin pointer and owning VC of the open packet.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= S_IDLE;
            rr     <= 1'b0;
            cur_vc <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr     <= rr_nxt;
            cur_vc <= cur_vc_nxt;
        end
    end

    // Per-VC credit counters; an ack at full credit is dropped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cred[0] <= CRED_MAX;
            cred[1] <= CRED_MAX;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (iss_on[v] && !iack[v])
                    cred[v] <= cred[v] - 1'b1;
                else if (iack[v] && !iss_on[v] && !at_max[v])
                    cred[v] <= cred[v] + 1'b1;
            end
        end
    end

    // Registered flit output to the router plus the sticky error flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ovalid <= issue;
            if (issue) begin
                odata <= stamped;
                ovch  <= issue_vc;
            end
            if (disc_err || ack_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_src_ni.sv
// Directed bench for noc_src_ni with two credits per VC.
module tb_noc_src_ni;

    logic        clk = 1'b0;
    logic        rst_;
    logic [1:0]  my_xpos, my_ypos;
    logic [34:0] h_data;
    logic        h_valid;
    logic        h_ready;
    logic [34:0] odata;
    logic        ovalid, ovch;
    logic [1:0]  iack, irdy, ilck;
    logic        err, idle;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    noc_src_ni #(.FIFO_DEPTH(4), .VC_DEPTH(2)) dut (
        .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
        .h_data(h_data), .h_valid(h_valid), .h_ready(h_ready),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .iack(iack), .irdy(irdy), .ilck(ilck), .err(err), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [34:0] f);
        h_data  = f;
        h_valid = 1'b1;
        step();
        h_valid = 1'b0;
    endtask

    task automatic pulse_ack(input logic [1:0] a, input int n);
        iack = a;
        repeat (n) step();
        iack = 2'b00;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        repeat (3) step();
        rst_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // T1: reset with random inputs
        my_xpos = 2'd2; my_ypos = 2'd1;
        rst_    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h_data  = {$urandom, $urandom};
            h_valid = 1'($urandom);
            iack    = 2'($urandom);
            irdy    = 2'($urandom);
            ilck    = 2'($urandom);
            step();
        end
        check("rst_ovalid", 35'(ovalid), 35'd0);
        check("rst_odata", odata, 35'd0);
        check("rst_hready", 35'(h_ready), 35'd0);
        check("rst_err", 35'(err), 35'd0);
        h_valid = 1'b0; iack = 2'b00; irdy = 2'b11; ilck = 2'b00;
        #2 rst_ = 1'b1;
        check("hready_pre_edge", 35'(h_ready), 35'd0);
        step();
        check("hready_after", 35'(h_ready), 35'd1);
        check("idle_after", 35'(idle), 35'd1);

        // T2: single head+tail flit, stamped, VC0; rr moves to VC1
        push({2'b11, 33'h1234});
        check("t2_lat_early", 35'(ovalid), 35'd0);
        step();
        check("t2_ovalid", 35'(ovalid), 35'd1);
        check("t2_ovch", 35'(ovch), 35'd0);
        check("t2_odata", odata, {2'b11, 33'h1264});
        step();
        check("t2_one_cycle", 35'(ovalid), 35'd0);
        pulse_ack(2'b01, 1);
        check("t2_idle", 35'(idle), 35'd1);
        push({2'b11, 33'h0});
        step();
        check("t2_rr_ovalid", 35'(ovalid), 35'd1);
        check("t2_rr_vc1", 35'(ovch), 35'd1);
        check("t2_rr_odata", odata, {2'b11, 33'h60});
        pulse_ack(2'b10, 1);

        // T3: 4-flit packet on VC0 with only two credits
        begin
            logic [34:0] pk [4];
            logic        ev [4];
            pk[0] = {2'b01, 33'hA0F}; pk[1] = {2'b00, 33'h1};
            pk[2] = {2'b00, 33'h2};   pk[3] = {2'b10, 33'h3};
            ev[0] = 1'b0; ev[1] = 1'b1; ev[2] = 1'b1; ev[3] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                push(pk[i]);
                check("t3_ovalid", 35'(ovalid), 35'(ev[i]));
                if (i == 1) check("t3_head", odata, {2'b01, 33'hA6F});
                if (i == 2) check("t3_body1", odata, pk[1]);
            end
            step();
            check("t3_stall", 35'(ovalid), 35'd0);
            check("t3_not_idle", 35'(idle), 35'd0);
            pulse_ack(2'b01, 1);
            check("t3_ack_edge", 35'(ovalid), 35'd0);
            step();
            check("t3_flit3", 35'(ovalid), 35'd1);
            check("t3_flit3_data", odata, pk[2]);
            check("t3_flit3_vc", 35'(ovch), 35'd0);
            pulse_ack(2'b01, 1);
            step();
            check("t3_tail", 35'(ovalid), 35'd1);
            check("t3_tail_data", odata, pk[3]);
            pulse_ack(2'b01, 2);
            check("t3_idle", 35'(idle), 35'd1);
        end

        // T4: VC0 locked -> VC1; lock on both ignored for the open packet
        ilck = 2'b01;
        push({2'b01, 33'h5});
        step();
        check("t4_head_ovalid", 35'(ovalid), 35'd1);
        check("t4_head_vc", 35'(ovch), 35'd1);
        check("t4_head_data", odata, {2'b01, 33'h65});
        ilck = 2'b11;
        push({2'b00, 33'h7});
        step();
        check("t4_body_ovalid", 35'(ovalid), 35'd1);
        check("t4_body_vc", 35'(ovch), 35'd1);
        iack = 2'b10;
        push({2'b10, 33'h8});
        iack = 2'b00;
        step();
        check("t4_tail_ovalid", 35'(ovalid), 35'd1);
        check("t4_tail_vc", 35'(ovch), 35'd1);
        check("t4_tail_data", odata, {2'b10, 33'h8});
        pulse_ack(2'b10, 2);
        ilck = 2'b00;
        check("t4_idle", 35'(idle), 35'd1);

        // T5: simultaneous ack and issue at cred=1, then an excess ack
        irdy = 2'b01;
        push({2'b11, 33'hA});
        step();
        push({2'b11, 33'hB});
        iack = 2'b01;
        step();
        iack = 2'b00;
        check("t5_issue", 35'(ovalid), 35'd1);
        check("t5_vc", 35'(ovch), 35'd0);
        check("t5_err0", 35'(err), 35'd0);
        pulse_ack(2'b01, 1);
        check("t5_err_still0", 35'(err), 35'd0);
        check("t5_idle", 35'(idle), 35'd1);
        pulse_ack(2'b01, 1);
        check("t5_err1", 35'(err), 35'd1);
        irdy = 2'b11;

        // T6: orphan body after reset is dropped and flagged
        do_reset();
        step();
        check("t6_err_cleared", 35'(err), 35'd0);
        push({2'b00, 33'h9});
        check("t6_no_ovalid_a", 35'(ovalid), 35'd0);
        step();
        check("t6_no_ovalid_b", 35'(ovalid), 35'd0);
        check("t6_err", 35'(err), 35'd1);
        push({2'b11, 33'h0});
        step();
        check("t6_ht_ovalid", 35'(ovalid), 35'd1);
        check("t6_ht_vc", 35'(ovch), 35'd0);
        check("t6_ht_data", odata, {2'b11, 33'h60});
        pulse_ack(2'b01, 1);

        // FIFO full then back-to-back drain across both VCs
        irdy = 2'b00;
        for (int i = 0; i < 4; i++) push({2'b11, 33'(i)});
        check("full_hready", 35'(h_ready), 35'd0);
        check("full_not_idle", 35'(idle), 35'd0);
        irdy = 2'b11;
        cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ovalid) cnt++;
            if (i == 1) check("b2b_second", 35'(ovalid), 35'd1);
        end
        check("b2b_count", 35'(cnt), 35'd4);
        pulse_ack(2'b11, 2);
        check("end_idle", 35'(idle), 35'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
